// File: rtl/sort_pkg.sv
// Shared types and constants for the sorting visualiser: controller state
// encoding, default geometry and the bar colours used by the pixel renderer.
package sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CMP,
        ST_SWAP,
        ST_DONE
    } state_t;

    localparam int N_BARS_DEF = 5;
    localparam int IDX_W_DEF  = 3;
    localparam int H_W_DEF    = 7;

    localparam logic [15:0] COLOR_BG    = 16'h0000;
    localparam logic [15:0] COLOR_BAR   = 16'hFFFF;
    localparam logic [15:0] COLOR_CUR_I = 16'h07E0;
    localparam logic [15:0] COLOR_CUR_J = 16'hF800;
    localparam logic [15:0] COLOR_MIN   = 16'h001F;
    localparam logic [15:0] COLOR_DONE  = 16'hFFE0;

    // Highlight priority used by the renderer: min beats j beats i.
    function automatic logic [15:0] bar_colour(input logic is_i, input logic is_j,
                                               input logic is_min, input logic sorted);
        if (sorted) return COLOR_DONE;
        if (is_min) return COLOR_MIN;
        if (is_j)   return COLOR_CUR_J;
        if (is_i)   return COLOR_CUR_I;
        return COLOR_BAR;
    endfunction

endpackage

// File: rtl/step_pacer.sv
// Paces sort steps: emits one tick every STEP_DELAY clocks while enabled,
// freezes while paused, and lets a step pulse force a tick during pause.
module step_pacer #(
    parameter int STEP_DELAY = 50000000,
    parameter int DLY_W      = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic pause,
    input  logic step,
    output logic tick
);

    localparam logic [DLY_W-1:0] LAST = DLY_W'(STEP_DELAY - 1);

    logic [DLY_W-1:0] delay_q;

    assign tick = enable && (pause ? step : (delay_q == LAST));

    // Counter restarts from zero every time the pacer is re-enabled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            delay_q <= '0;
        end else if (!enable || tick) begin
            delay_q <= '0;
        end else if (!pause) begin
            delay_q <= delay_q + 1'b1;
        end
    end

endmodule

// File: rtl/sort_step_controller.sv
// Selection-sort sequencer for the bar-height register file: one compare per
// paced step, swaps issued over a valid/ready handshake.
module sort_step_controller
    import sort_pkg::*;
#(
    parameter int N_BARS     = N_BARS_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int H_W        = H_W_DEF,
    parameter int STEP_DELAY = 50000000,
    parameter int DLY_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             step,
    output logic [IDX_W-1:0] rd_a_idx,
    output logic [IDX_W-1:0] rd_b_idx,
    input  logic [H_W-1:0]   rd_a_h,
    input  logic [H_W-1:0]   rd_b_h,
    output logic             swap_valid,
    input  logic             swap_ready,
    output logic [IDX_W-1:0] swap_a,
    output logic [IDX_W-1:0] swap_b,
    output logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] cur_j,
    output logic [IDX_W-1:0] min_idx,
    output logic             busy,
    output logic             done,
    output logic [7:0]       cmp_count,
    output logic [7:0]       swap_count
);

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_BARS - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_BARS - 2);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO    = IDX_W'(2);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d, m_q, m_d;
    logic [7:0]       cmp_q, cmp_d, swp_q, swp_d;
    logic             abort_q, abort_d;
    logic             tick;
    logic             need_swap;

    assign need_swap = (m_q != i_q);

    step_pacer #(
        .STEP_DELAY(STEP_DELAY),
        .DLY_W     (DLY_W)
    ) u_pacer (
        .clk   (clk),
        .resetn(resetn),
        .enable(state_q == ST_WAIT),
        .pause (pause),
        .step  (step),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            cmp_q   <= '0;
            swp_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            cmp_q   <= cmp_d;
            swp_q   <= swp_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        cmp_d   = cmp_q;
        swp_d   = swp_q;
        abort_d = abort_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && abort) begin
                    state_d = ST_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    m_d     = '0;
                end else if (start && !abort) begin
                    state_d = ST_WAIT;
                    i_d     = '0;
                    j_d     = ONE;
                    m_d     = '0;
                    cmp_d   = '0;
                    swp_d   = '0;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    m_d     = '0;
                end else if (tick) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    m_d     = '0;
                end else begin
                    if (rd_a_h < rd_b_h) m_d = j_q;
                    if (cmp_q != 8'hFF) cmp_d = cmp_q + 8'd1;
                    if (j_q == LAST_J) begin
                        state_d = ST_SWAP;
                    end else begin
                        j_d     = j_q + ONE;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_SWAP: begin
                // An abort during an outstanding request waits for the handshake.
                if (!need_swap || swap_ready) begin
                    abort_d = 1'b0;
                    if (need_swap && swp_q != 8'hFF) swp_d = swp_q + 8'd1;
                    if (abort || abort_q) begin
                        state_d = ST_IDLE;
                        i_d     = '0;
                        j_d     = '0;
                        m_d     = '0;
                    end else if (i_q == LAST_I) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + ONE;
                        j_d     = i_q + TWO;
                        m_d     = i_q + ONE;
                        state_d = ST_WAIT;
                    end
                end else if (abort) begin
                    abort_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_a_idx   = j_q;
    assign rd_b_idx   = m_q;
    assign swap_valid = (state_q == ST_SWAP) && need_swap;
    assign swap_a     = i_q;
    assign swap_b     = m_q;
    assign cur_i      = i_q;
    assign cur_j      = j_q;
    assign min_idx    = m_q;
    assign busy       = (state_q == ST_WAIT) || (state_q == ST_CMP) || (state_q == ST_SWAP);
    assign done       = (state_q == ST_DONE);
    assign cmp_count  = cmp_q;
    assign swap_count = swp_q;

endmodule
